// File: rtl/dds_multi.sv
// Multi-channel DDS: one phase accumulator per voice. A single quarter-wave sine ROM
// is shared between voices in turn after each sampling pulse.
module dds_multi #(
    parameter int CHANNELS = 4,
    parameter int PHASE_W  = 22,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    localparam int MIX_W   = DATA_W + $clog2(CHANNELS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sampling_pulse,
    input  logic [CHANNELS*PHASE_W-1:0]   k,
    input  logic [CHANNELS-1:0]           ch_en,
    input  logic [CHANNELS-1:0]           phase_clear,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-2:0]             rom_data,
    output logic [CHANNELS*DATA_W-1:0]    sample,
    output logic signed [MIX_W-1:0]       mix,
    output logic                          busy,
    output logic                          new_sample_ready,
    output logic                          overrun
);

    localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;
    logic accept;

    logic [CNT_W-1:0]         cnt;
    logic [PHASE_W-1:0]       phase [CHANNELS];
    logic [PHASE_W-1:0]       snap  [CHANNELS];
    logic [CHANNELS-1:0]      en_snap;

    logic                     vld_p1;
    logic [CNT_W-1:0]         ch_p1;
    logic                     sign_p1;
    logic                     en_p1;
    logic signed [DATA_W-1:0] wb_val;

    logic signed [DATA_W-1:0] shadow   [CHANNELS];
    logic signed [DATA_W-1:0] sample_q [CHANNELS];
    logic signed [MIX_W-1:0]  mix_acc;

    // The second quadrant reads the table backwards. Index 0 would wrap to 2^ADDR_W,
    // so it is clamped to the last entry, which holds the peak.
    function automatic logic [ADDR_W-1:0] quarter_addr(input logic [PHASE_W-1:0] ph);
        logic              mirror;
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W:0]   refl;
        mirror = ph[PHASE_W-2];
        idx    = ph[PHASE_W-3 -: ADDR_W];
        refl   = {1'b1, {ADDR_W{1'b0}}} - {1'b0, idx};
        if (!mirror)
            return idx;
        else if (idx == '0)
            return {ADDR_W{1'b1}};
        else
            return refl[ADDR_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] signed_value(input logic neg,
                                                              input logic [DATA_W-2:0] mag);
        logic signed [DATA_W-1:0] ext;
        ext = signed'({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (sampling_pulse) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN:     if (cnt == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            vld_p1           <= 1'b0;
            new_sample_ready <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= (state == RUN && cnt != LAST) ? cnt + 1'b1 : '0;
            vld_p1           <= (state == RUN);
            new_sample_ready <= (state == DRAIN);
            overrun          <= sampling_pulse && (state != IDLE);
        end
    end

    // The snapshot captures the phase before this edge's advance or clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                phase[i] <= '0;
                snap[i]  <= '0;
            end
            en_snap <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (phase_clear[i])
                    phase[i] <= '0;
                else if (accept && ch_en[i])
                    phase[i] <= phase[i] + k[i*PHASE_W +: PHASE_W];
                if (accept)
                    snap[i] <= phase[i];
            end
            if (accept)
                en_snap <= ch_en;
        end
    end

    assign rom_addr = quarter_addr(snap[cnt]);

    // Stage p1: address issued last cycle, ROM data valid now.
    assign wb_val = en_p1 ? signed_value(sign_p1, rom_data) : '0;

    always_ff @(posedge clk) begin
        ch_p1   <= cnt;
        sign_p1 <= snap[cnt][PHASE_W-1];
        en_p1   <= en_snap[cnt];
        if (accept)
            mix_acc <= '0;
        else if (vld_p1)
            mix_acc <= mix_acc + MIX_W'(wb_val);
        if (vld_p1)
            shadow[ch_p1] <= wb_val;
    end

    // The last channel's value is merged directly into the published frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++)
                sample_q[i] <= '0;
            mix <= '0;
        end else if (state == DRAIN) begin
            for (int i = 0; i < CHANNELS; i++)
                sample_q[i] <= (ch_p1 == CNT_W'(i)) ? wb_val : shadow[i];
            mix <= mix_acc + MIX_W'(wb_val);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_sample
        assign sample[g*DATA_W +: DATA_W] = sample_q[g];
    end

endmodule

// File: tb/tb_dds_multi.sv
// Bench for dds_multi: table of frames plus hand sequences; a scoreboard queue
// checks every completed frame against its expected samples, mix and latency.
module tb_dds_multi;

    localparam int CH = 4;
    localparam int PW = 22;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MW = 18;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   sampling_pulse = 1'b0;
    logic [CH*PW-1:0]       k = '0;
    logic [CH-1:0]          ch_en = '0;
    logic [CH-1:0]          phase_clear = '0;
    logic [AW-1:0]          rom_addr;
    logic [DW-2:0]          rom_data = '0;
    logic [CH*DW-1:0]       sample;
    logic signed [MW-1:0]   mix;
    logic                   busy;
    logic                   new_sample_ready;
    logic                   overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_ready = 0;

    typedef struct {
        logic [CH*DW-1:0]     s;
        logic signed [MW-1:0] m;
        int                   t0;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [CH*PW-1:0]     kv;
        logic [CH-1:0]        en;
        logic [CH-1:0]        clr;
        logic [CH*DW-1:0]     es;
        logic signed [MW-1:0] em;
    } vec_t;
    vec_t tbl[6];

    logic [PW-1:0] mph [CH];

    dds_multi #(.CHANNELS(CH), .PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .sampling_pulse(sampling_pulse), .k(k),
        .ch_en(ch_en), .phase_clear(phase_clear), .rom_addr(rom_addr),
        .rom_data(rom_data), .sample(sample), .mix(mix), .busy(busy),
        .new_sample_ready(new_sample_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-2:0] rom_fn(input logic [AW-1:0] a);
        return {a, 5'b0} | {10'b0, a[9:5]};
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom_fn(rom_addr);
    end

    function automatic logic [AW-1:0] m_addr(input logic [PW-1:0] p);
        int idx;
        idx = int'(p[PW-3 -: AW]);
        if (p[PW-2] == 1'b0) return AW'(idx);
        if (idx == 0) return AW'((1 << AW) - 1);
        return AW'((1 << AW) - idx);
    endfunction

    function automatic int m_val(input logic [PW-1:0] p);
        int mag;
        mag = int'(rom_fn(m_addr(p)));
        return p[PW-1] ? -mag : mag;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && new_sample_ready) begin
            n_ready++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("sample", sample, e.s);
                check("mix", mix, e.m);
                check("latency", cyc - e.t0, 6);
            end
        end
    end

    // Drives one pulse from idle; returns in cycle T+1 with the channel-0 address.
    task automatic do_frame(input logic [CH*PW-1:0] kv, input logic [CH-1:0] en,
                            input logic [CH-1:0] clr, input bit push, input bit use_model,
                            input logic [CH*DW-1:0] es, input logic signed [MW-1:0] em,
                            output logic [AW-1:0] addr_t1, output logic [AW-1:0] maddr);
        int n;
        exp_t e;
        int v;
        int msum;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_wait: got busy=1 expected 0");
        end
        e.s = es;
        e.m = em;
        if (use_model) begin
            msum = 0;
            for (int i = 0; i < CH; i++) begin
                v = en[i] ? m_val(mph[i]) : 0;
                e.s[i*DW +: DW] = DW'(v);
                msum += v;
            end
            e.m = MW'(msum);
        end
        e.t0 = cyc;
        maddr = m_addr(mph[0]);
        if (push) sb.push_back(e);
        k = kv;
        ch_en = en;
        phase_clear = clr;
        sampling_pulse = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (clr[i]) mph[i] = '0;
            else if (en[i]) mph[i] = mph[i] + kv[i*PW +: PW];
        end
        @(negedge clk);
        sampling_pulse = 1'b0;
        phase_clear = '0;
        addr_t1 = rom_addr;
    endtask

    task automatic finish_frame();
        int bc;
        bc = 0;
        repeat (7) begin
            if (busy) bc++;
            @(negedge clk);
        end
        check("busy_cycles", bc, 5);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        logic [AW-1:0] a1, ma;
        logic [AW-1:0] seq6 [6];
        int r0;

        tbl[0] = '{{4{22'h040000}}, 4'hF, 4'h0, '0, 18'sd0};
        tbl[1] = '{'0, 4'hF, 4'hF, {4{16'h2008}}, 18'sd32800};
        tbl[2] = '{{22'h300000, 22'h100000, 22'h100000, 22'h100000}, 4'hF, 4'h0, '0, 18'sd0};
        tbl[3] = '{'0, 4'hF, 4'h0, {16'h8001, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 18'sd65534};
        tbl[4] = '{{22'h100000, 22'h0, 22'h0, 22'h0}, 4'h7, 4'h0,
                   {16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 18'sd98301};
        tbl[5] = tbl[3];
        seq6 = '{10'd0, 10'd256, 10'd512, 10'd768, 10'd1023, 10'd768};
        for (int i = 0; i < CH; i++) mph[i] = '0;

        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", new_sample_ready, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_sample", sample, 0);
        check("rst_mix", mix, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_frame(tbl[i].kv, tbl[i].en, tbl[i].clr, 1'b1, 1'b0, tbl[i].es, tbl[i].em, a1, ma);
            finish_frame();
        end

        // pulse at T and T+3: second is dropped
        r0 = n_ready;
        do_frame('0, 4'hF, 4'h0, 1'b1, 1'b0, tbl[3].es, tbl[3].em, a1, ma);
        @(negedge clk);
        @(negedge clk);
        check("overrun_t3", overrun, 0);
        sampling_pulse = 1'b1;
        @(negedge clk);
        sampling_pulse = 1'b0;
        check("overrun_t4", overrun, 1);
        @(negedge clk);
        check("overrun_t5", overrun, 0);
        repeat (6) @(negedge clk);
        check("overrun_one_ready", n_ready - r0, 1);
        check("overrun_sb", sb.size(), 0);

        // clear with pulse: snapshot is the old phase
        do_frame('0, 4'hF, 4'hF, 1'b1, 1'b1, '0, '0, a1, ma);
        finish_frame();

        for (int j = 0; j < 17; j++) begin
            do_frame({66'b0, 22'h040000}, 4'h1, 4'h0, 1'b1, 1'b1, '0, '0, a1, ma);
            if (j < 6) check("rom_addr_seq", a1, seq6[j]);
            else check("rom_addr_model", a1, ma);
            finish_frame();
        end

        // reset mid-RUN
        do_frame('0, 4'hF, 4'h0, 1'b0, 1'b0, '0, '0, a1, ma);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_rom_addr", rom_addr, 0);
        check("midrst_sample", sample, 0);
        check("midrst_mix", mix, 0);
        check("midrst_ready", new_sample_ready, 0);
        for (int i = 0; i < CH; i++) mph[i] = '0;
        @(negedge clk);
        reset = 1'b1;
        r0 = n_ready;
        repeat (8) @(negedge clk);
        check("midrst_no_ready", n_ready - r0, 0);

        do_frame({4{22'h040000}}, 4'hF, 4'h0, 1'b1, 1'b0, '0, 18'sd0, a1, ma);
        finish_frame();
        do_frame('0, 4'hF, 4'h0, 1'b1, 1'b0, {4{16'h2008}}, 18'sd32800, a1, ma);
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_multi.md
# dds_multi

Parametrised multi-channel direct digital synthesiser for the music player audio path. Holds one phase accumulator per channel and time-multiplexes a single external quarter-wave sine ROM across all channels after each sampling pulse. Produces per-channel signed samples plus a full-precision mix, with a completion strobe for the downstream codec/mixer logic.

## Interface
- CHANNELS, 4, number of voices (≥1)
- PHASE_W, 22, phase accumulator width (≥ ADDR_W+2)
- ADDR_W, 10, quarter-wave ROM address width
- DATA_W, 16, signed sample width; ROM holds unsigned quarter sine, max 2^(DATA_W-1)-1
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- sampling_pulse  in  1  one-cycle request for a new sample frame
- k  in  CHANNELS*PHASE_W  per-channel phase increment, channel i at [i*PHASE_W +: PHASE_W]
- ch_en  in  CHANNELS  channel enable
- phase_clear  in  CHANNELS  synchronous per-channel accumulator clear
- rom_addr  out  ADDR_W  address to the shared sine ROM
- rom_data  in  DATA_W-1  ROM output, registered one cycle after rom_addr
- sample  out  CHANNELS*DATA_W  signed per-channel samples
- mix  out  DATA_W+$clog2(CHANNELS)  signed sum of enabled channels (DATA_W when CHANNELS=1)
- busy  out  1  frame in progress
- new_sample_ready  out  1  one-cycle strobe, sample/mix updated
- overrun  out  1  one-cycle strobe, pulse dropped while busy

## Operation
- Phase decode per channel: sign = phase[PHASE_W-1], mirror = phase[PHASE_W-2], idx = phase[PHASE_W-3 -: ADDR_W].
- ROM address: mirror=0 → idx; mirror=1 → 2^ADDR_W − idx, except idx=0 → 2^ADDR_W−1 (clamp at quarter peak).
- Value: rom_data zero-extended to DATA_W; negated (two's complement) when sign=1. No overflow possible.
- FSM: IDLE → RUN → DRAIN → IDLE.
  - IDLE: busy=0. sampling_pulse accepted: snapshot all phases, clear mix accumulator, channel counter=0, go RUN. Every accumulator i with ch_en[i]=1 advances phase += k_i (mod 2^PHASE_W) at the same edge.
  - RUN: drive rom_addr for snapshot of channel counter; counter increments each cycle; after channel CHANNELS−1 go DRAIN.
  - DRAIN: one cycle for the last ROM read; then IDLE with new_sample_ready.
- Write-back: one cycle after each address issue, the channel's signed value is stored in sample[i] and added to the mix accumulator; disabled channels store 0 and add 0 (still sequenced, fixed latency).
- sample and mix change only at frame completion (double-buffered); they hold between frames.
- phase_clear[i]=1: accumulator i becomes 0 at next edge, overriding advance; a snapshot taken at that same edge uses the pre-clear value.
- ch_en low: accumulator holds its value.
- sampling_pulse while busy=1 or in the completion cycle's preceding states: dropped, overrun pulses next cycle, no state change.
- reset low (any time, including mid-frame): immediately to IDLE; accumulators, snapshots, sample, mix, rom_addr = 0; busy, new_sample_ready, overrun = 0. First frame after reset yields all samples 0 (phase 0).

## Timing
- Pulse accepted in cycle T; rom_addr for channel i valid in T+1+i; rom_data for channel i in T+2+i.
- busy high T+1 .. T+CHANNELS+1.
- new_sample_ready high in T+CHANNELS+2 with sample/mix valid; latency CHANNELS+2 cycles (6 at default).
- Next pulse accepted from cycle T+CHANNELS+2 onward (busy low).
- k, ch_en sampled at the accepting edge only; changes mid-frame affect the next frame.

## Test plan
- Reset then one pulse, k0=0x40000, all enabled → new_sample_ready exactly 6 cycles later, all samples 0, mix 0; busy high 5 cycles.
- Repeated pulses on ch0 with k0=0x40000 → rom_addr sequence 0, 256, 512, 768, 1023, 768, …; sample sign negative from phase 2^21 onward; wraps after 16 frames.
- Phase 2^20 exactly (mirror=1, idx=0) → rom_addr 1023, sample = rom[1023] = 32767; phase 3·2^20 → sample −32767.
- Four channels at rom peak with mixed signs (+,+,+,−) → mix = 65534; ch_en=4'b0111 → ch3 sample 0, its phase frozen, mix = 98301.
- Pulse at T and T+3 → second dropped, overrun high at T+4, one new_sample_ready only.
- reset asserted mid-RUN → busy, outputs 0 asynchronously; phase_clear with pulse same cycle → snapshot old phase, accumulator 0 afterwards.
